// File: rtl/rk2040_pkg.sv
// Shared constants and types for the RK2040 interrupt controller.
package rk2040_pkg;

    localparam int unsigned N_IRQ_DEF = 24;

    // Config register addresses
    localparam logic [1:0] CFG_EN   = 2'd0;
    localparam logic [1:0] CFG_RISE = 2'd1;
    localparam logic [1:0] CFG_FALL = 2'd2;
    localparam logic [1:0] CFG_PEND = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irqState_t;

endpackage

// File: rtl/rk_irq_controller_if.sv
// Pin, config and core-handshake bundle of the interrupt controller.
interface rk_irq_controller_if
    import rk2040_pkg::*;
#(
    parameter int unsigned N_IRQ = N_IRQ_DEF
);
    localparam int unsigned VW = $clog2(N_IRQ);

    logic [N_IRQ-1:0] pins;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [N_IRQ-1:0] cfg_wdata;
    logic [N_IRQ-1:0] cfg_rdata;
    logic             gie;
    logic             irq_req;
    logic [VW-1:0]    irq_vector;
    logic             irq_ack;
    logic             irq_done;
    logic             irq_active;

    // Core / pad side
    modport master (
        output pins, cfg_we, cfg_addr, cfg_wdata, gie, irq_ack, irq_done,
        input  cfg_rdata, irq_req, irq_vector, irq_active
    );

    // Controller side
    modport slave (
        input  pins, cfg_we, cfg_addr, cfg_wdata, gie, irq_ack, irq_done,
        output cfg_rdata, irq_req, irq_vector, irq_active
    );

endinterface

// File: rtl/rk_irq_sync_edge.sv
// One interrupt line: synchroniser chain, delay flop, rise/fall qualification.
module rk_irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic riseSel,
    input  logic fallSel,
    output logic edgeHit_c
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   prevQ;
    logic                   level;

    assign level = syncQ[SYNC_STAGES-1];

    // Synchronise the async pin and keep the previous synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ <= '0;
            prevQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], pin};
            prevQ <= level;
        end
    end

    assign edgeHit_c = (level & ~prevQ & riseSel) | (~level & prevQ & fallSel);

endmodule

// File: rtl/rk_irq_controller.sv
// Edge-triggered interrupt controller: pending latch, priority encode, req/ack/done FSM.
module rk_irq_controller
    import rk2040_pkg::*;
#(
    parameter int unsigned N_IRQ       = N_IRQ_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    rk_irq_controller_if.slave bus
);

    localparam int unsigned VW         = $clog2(N_IRQ);
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned AW         = $clog2(ARM_CYCLES + 1);

    logic [AW-1:0]    armCnt;
    logic             armed;
    logic [N_IRQ-1:0] edgeRaw;
    logic [N_IRQ-1:0] edgeHit;
    logic [N_IRQ-1:0] en;
    logic [N_IRQ-1:0] riseSel;
    logic [N_IRQ-1:0] fallSel;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] pendNext;
    logic [N_IRQ-1:0] pendKeep;
    logic [N_IRQ-1:0] enNext;
    logic [N_IRQ-1:0] w1cClr;
    logic [N_IRQ-1:0] ackClr;
    logic [N_IRQ-1:0] reqMask;
    logic [VW-1:0]    winner;
    logic [VW-1:0]    vecQ;
    logic [VW-1:0]    vecNext;
    irqState_t        state;
    irqState_t        stateNext;
    logic             reqQ;
    logic             reqNext;
    logic             activeQ;
    logic             activeNext;
    logic             withdraw;

    // Mask edges until the sync chain and delay flop hold real pin levels
    always_ff @(posedge clk) begin
        if (rst) begin
            armCnt <= '0;
        end else if (armCnt != AW'(ARM_CYCLES)) begin
            armCnt <= armCnt + AW'(1);
        end
    end

    assign armed   = (armCnt == AW'(ARM_CYCLES));
    assign edgeHit = armed ? edgeRaw : '0;

    for (genvar g = 0; g < N_IRQ; g++) begin : gLine
        rk_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
            .clk       (clk),
            .rst       (rst),
            .pin       (bus.pins[g]),
            .riseSel   (riseSel[g]),
            .fallSel   (fallSel[g]),
            .edgeHit_c (edgeRaw[g])
        );
    end

    // Pending update: edge-set beats ack-clear beats W1C-clear
    always_comb begin
        w1cClr   = (bus.cfg_we && bus.cfg_addr == CFG_PEND) ? bus.cfg_wdata : '0;
        enNext   = (bus.cfg_we && bus.cfg_addr == CFG_EN) ? bus.cfg_wdata : en;
        ackClr   = (state == REQ && bus.irq_ack) ? (N_IRQ'(1) << vecQ) : '0;
        pendKeep = (pend & ~w1cClr) | edgeHit;
        pendNext = (pend & ~w1cClr & ~ackClr) | edgeHit;
    end

    // Config and pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= '0;
            riseSel <= '0;
            fallSel <= '0;
            pend    <= '0;
        end else begin
            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    CFG_EN:   en      <= bus.cfg_wdata;
                    CFG_RISE: riseSel <= bus.cfg_wdata;
                    CFG_FALL: fallSel <= bus.cfg_wdata;
                    default:  ;
                endcase
            end
            pend <= pendNext;
        end
    end

    // Register readback
    always_comb begin
        case (bus.cfg_addr)
            CFG_EN:   bus.cfg_rdata = en;
            CFG_RISE: bus.cfg_rdata = riseSel;
            CFG_FALL: bus.cfg_rdata = fallSel;
            default:  bus.cfg_rdata = pend;
        endcase
    end

    // Lowest enabled pending index wins
    always_comb begin
        reqMask = pend & en;
        winner  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (reqMask[i]) winner = VW'(i);
        end
    end

    // Request is withdrawn if its line would stop being pending+enabled, or gie drops
    assign withdraw = !bus.gie || !(pendKeep[vecQ] && enNext[vecQ]);

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            reqQ    <= 1'b0;
            vecQ    <= '0;
            activeQ <= 1'b0;
        end else begin
            state   <= stateNext;
            reqQ    <= reqNext;
            vecQ    <= vecNext;
            activeQ <= activeNext;
        end
    end

    // FSM next-state and output decode
    always_comb begin
        stateNext  = state;
        reqNext    = reqQ;
        vecNext    = vecQ;
        activeNext = activeQ;
        case (state)
            IDLE: begin
                if (bus.gie && |reqMask) begin
                    stateNext = REQ;
                    reqNext   = 1'b1;
                    vecNext   = winner;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    stateNext  = SERVICE;
                    reqNext    = 1'b0;
                    activeNext = 1'b1;
                end else if (withdraw) begin
                    stateNext = IDLE;
                    reqNext   = 1'b0;
                end
            end
            SERVICE: begin
                if (bus.irq_done) begin
                    stateNext  = IDLE;
                    activeNext = 1'b0;
                end
            end
            default: begin
                stateNext  = IDLE;
                reqNext    = 1'b0;
                activeNext = 1'b0;
            end
        endcase
    end

    assign bus.irq_req    = reqQ;
    assign bus.irq_vector = vecQ;
    assign bus.irq_active = activeQ;

endmodule

// File: tb/tb_rk_irq_controller.sv
// Directed bench for rk_irq_controller: reset arming, latency, priority, withdraw, ack/edge races.
module tb_rk_irq_controller;
    import rk2040_pkg::*;

    localparam int unsigned N = 24;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    rk_irq_controller_if #(.N_IRQ(N)) bus ();

    rk_irq_controller #(.N_IRQ(N), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chkReg(input string tag, input logic [1:0] a, input logic [23:0] exp);
        bus.cfg_addr = a;
        #1;
        chk(tag, 32'(bus.cfg_rdata), 32'(exp));
        bus.cfg_addr = CFG_PEND;
    endtask

    task automatic chkReq(input string tag, input logic req, input logic [4:0] vec);
        chk({tag, "_req"}, 32'(bus.irq_req), 32'(req));
        if (req) chk({tag, "_vec"}, 32'(bus.irq_vector), 32'(vec));
    endtask

    task automatic cfgWrite(input logic [1:0] a, input logic [23:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        step(1);
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = CFG_PEND;
    endtask

    initial begin
        rst           = 1'b1;
        bus.pins      = '0;
        bus.pins[5]   = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = CFG_PEND;
        bus.cfg_wdata = '0;
        bus.gie       = 1'b0;
        bus.irq_ack   = 1'b0;
        bus.irq_done  = 1'b0;

        // Reset values
        step(3);
        chk("rst_req", 32'(bus.irq_req), 32'd0);
        chk("rst_vec", 32'(bus.irq_vector), 32'd0);
        chk("rst_active", 32'(bus.irq_active), 32'd0);
        chkReg("rst_pend", CFG_PEND, 24'h0);
        chkReg("rst_en", CFG_EN, 24'h0);

        // 1: pin 5 high through reset must not produce a rising edge
        rst = 1'b0;
        cfgWrite(CFG_RISE, 24'hFFFFFF);
        cfgWrite(CFG_EN, 24'hFFFFFF);
        bus.gie = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("t1_noreq", 32'(bus.irq_req), 32'd0);
        end
        chkReg("t1_pend", CFG_PEND, 24'h0);
        chkReg("t1_rise_rb", CFG_RISE, 24'hFFFFFF);

        // 2: falling edge on pin 5, request exactly 3 clocks after sampling
        cfgWrite(CFG_EN, 24'h0000A0);
        cfgWrite(CFG_RISE, 24'h0000A0);
        cfgWrite(CFG_FALL, 24'h0000A0);
        chkReg("t2_fall_rb", CFG_FALL, 24'h0000A0);
        bus.pins[5] = 1'b0;
        step(1);
        chk("t2_e0", 32'(bus.irq_req), 32'd0);
        step(1);
        chk("t2_e1", 32'(bus.irq_req), 32'd0);
        step(1);
        chk("t2_e2", 32'(bus.irq_req), 32'd0);
        chkReg("t2_pend", CFG_PEND, 24'h000020);
        step(1);
        chkReq("t2_e3", 1'b1, 5'd5);
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
        chk("t2_ack_req", 32'(bus.irq_req), 32'd0);
        chk("t2_ack_active", 32'(bus.irq_active), 32'd1);
        chkReg("t2_ack_pend", CFG_PEND, 24'h0);

        // 3: edge during SERVICE only pends; request follows done by one cycle
        bus.pins[7] = 1'b1;
        step(3);
        chkReg("t3_pend", CFG_PEND, 24'h000080);
        step(2);
        chk("t3_svc_noreq", 32'(bus.irq_req), 32'd0);
        chk("t3_svc_active", 32'(bus.irq_active), 32'd1);
        bus.irq_done = 1'b1;
        step(1);
        bus.irq_done = 1'b0;
        chk("t3_done_req", 32'(bus.irq_req), 32'd0);
        chk("t3_done_active", 32'(bus.irq_active), 32'd0);
        step(1);
        chkReq("t3_next", 1'b1, 5'd7);

        // 4: simultaneous edges on 7 and 5, lower index first
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
        bus.irq_done = 1'b1;
        step(1);
        bus.irq_done = 1'b0;
        chk("t4_idle_active", 32'(bus.irq_active), 32'd0);
        bus.pins[7] = 1'b0;
        bus.pins[5] = 1'b1;
        step(3);
        chkReg("t4_pend", CFG_PEND, 24'h0000A0);
        chk("t4_e2_req", 32'(bus.irq_req), 32'd0);
        step(1);
        chkReq("t4_first", 1'b1, 5'd5);
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
        chkReg("t4_ack_pend", CFG_PEND, 24'h000080);
        bus.irq_done = 1'b1;
        step(1);
        bus.irq_done = 1'b0;
        chk("t4_done_req", 32'(bus.irq_req), 32'd0);
        step(1);
        chkReq("t4_second", 1'b1, 5'd7);

        // 5: W1C of the requested line withdraws the request
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = CFG_PEND;
        bus.cfg_wdata = 24'h000080;
        step(1);
        bus.cfg_we    = 1'b0;
        chk("t5_wd_req", 32'(bus.irq_req), 32'd0);
        chk("t5_wd_active", 32'(bus.irq_active), 32'd0);
        chkReg("t5_wd_pend", CFG_PEND, 24'h0);
        step(1);
        chk("t5_idle_req", 32'(bus.irq_req), 32'd0);
        bus.pins[7] = 1'b1;
        step(4);
        chkReq("t5_rereq", 1'b1, 5'd7);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = CFG_PEND;
        bus.cfg_wdata = 24'h000080;
        bus.irq_ack   = 1'b1;
        step(1);
        bus.cfg_we    = 1'b0;
        bus.irq_ack   = 1'b0;
        chk("t5_ackwin_req", 32'(bus.irq_req), 32'd0);
        chk("t5_ackwin_active", 32'(bus.irq_active), 32'd1);
        chkReg("t5_ackwin_pend", CFG_PEND, 24'h0);
        bus.irq_done = 1'b1;
        step(1);
        bus.irq_done = 1'b0;
        chk("t5_done_active", 32'(bus.irq_active), 32'd0);

        // 6: new edge on bit 5 lands on the same edge as its ack-clear
        step(1);
        bus.pins[5] = 1'b0;
        step(2);
        bus.pins[5] = 1'b1;
        step(2);
        chkReq("t6_req", 1'b1, 5'd5);
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
        chkReg("t6_pend_kept", CFG_PEND, 24'h000020);
        chk("t6_active", 32'(bus.irq_active), 32'd1);
        chk("t6_ack_req", 32'(bus.irq_req), 32'd0);
        bus.irq_done = 1'b1;
        step(1);
        bus.irq_done = 1'b0;
        chk("t6_done_req", 32'(bus.irq_req), 32'd0);
        step(1);
        chkReq("t6_rereq", 1'b1, 5'd5);

        // Reset while requesting
        rst = 1'b1;
        step(1);
        chk("rst2_req", 32'(bus.irq_req), 32'd0);
        chk("rst2_vec", 32'(bus.irq_vector), 32'd0);
        chk("rst2_active", 32'(bus.irq_active), 32'd0);
        chkReg("rst2_pend", CFG_PEND, 24'h0);
        chkReg("rst2_en", CFG_EN, 24'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
